// File: rtl/boot_rom_loader.sv
// Copies BOOT_LEN bytes from a registered-read boot ROM into a core through a
// backpressured download port, then pulses execute_enable once.
module boot_rom_loader #(
    parameter int unsigned BOOT_LEN  = 276,
    parameter logic [15:0] LOAD_BASE = 16'h0000,
    parameter logic [15:0] EXEC_ADDR = 16'h0000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    input  logic        dn_wait,
    output logic        execute_enable,
    output logic [15:0] execute_addr,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(BOOT_LEN - 1);

    state_t      state_q;
    logic [16:0] idx_q;
    logic [16:0] idx_d;
    logic        prime_q;
    logic [15:0] rom_addr_q;
    logic        dn_go_q;
    logic        dn_wr_q;
    logic [15:0] dn_addr_q;
    logic [7:0]  dn_data_q;
    logic        execute_enable_q;
    logic        cpu_hold_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  checksum_q;

    assign idx_d = idx_q + 17'd1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q          <= IDLE;
            idx_q            <= 17'd0;
            prime_q          <= 1'b0;
            rom_addr_q       <= 16'd0;
            dn_go_q          <= 1'b0;
            dn_wr_q          <= 1'b0;
            dn_addr_q        <= 16'd0;
            dn_data_q        <= 8'd0;
            execute_enable_q <= 1'b0;
            cpu_hold_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            checksum_q       <= 8'd0;
        end else begin
            execute_enable_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        idx_q      <= 17'd0;
                        prime_q    <= 1'b1;
                        rom_addr_q <= 16'd0;
                        checksum_q <= 8'd0;
                        done_q     <= 1'b0;
                        dn_go_q    <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FETCH: begin
                    // Byte 0 has no prefetch in flight, so its read needs one extra cycle.
                    if (prime_q) begin
                        prime_q <= 1'b0;
                    end else begin
                        state_q    <= WRITE;
                        dn_data_q  <= rom_data;
                        dn_addr_q  <= LOAD_BASE + idx_q[15:0];
                        dn_wr_q    <= 1'b1;
                        rom_addr_q <= idx_d[15:0];
                    end
                end
                WRITE: begin
                    if (!dn_wait) begin
                        dn_wr_q    <= 1'b0;
                        checksum_q <= checksum_q + dn_data_q;
                        if (idx_q < LAST_IDX) begin
                            idx_q   <= idx_d;
                            state_q <= FETCH;
                        end else begin
                            state_q          <= EXEC;
                            execute_enable_q <= 1'b1;
                            dn_go_q          <= 1'b0;
                            cpu_hold_q       <= 1'b0;
                            busy_q           <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr       = rom_addr_q;
    assign dn_go          = dn_go_q;
    assign dn_wr          = dn_wr_q;
    assign dn_addr        = dn_addr_q;
    assign dn_data        = dn_data_q;
    assign execute_enable = execute_enable_q;
    assign execute_addr   = EXEC_ADDR;
    assign cpu_hold       = cpu_hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign checksum       = checksum_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Bench for boot_rom_loader: a default-size instance driven by directed and
// random loads, and a one-byte instance driven from a vector table.
module tb_boot_rom_loader;

    logic clk;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic        reset_a = 1'b0, start_a = 1'b0, dn_wait_a = 1'b0;
    logic [15:0] rom_addr_a, dn_addr_a, execute_addr_a;
    logic [7:0]  rom_data_a, dn_data_a, checksum_a;
    logic        dn_go_a, dn_wr_a, execute_enable_a, cpu_hold_a, busy_a, done_a;
    logic [7:0]  rom_a [0:65535];

    boot_rom_loader dut_a (
        .clk_sys(clk), .reset(reset_a), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .dn_go(dn_go_a), .dn_wr(dn_wr_a), .dn_addr(dn_addr_a), .dn_data(dn_data_a),
        .dn_wait(dn_wait_a), .execute_enable(execute_enable_a), .execute_addr(execute_addr_a),
        .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .checksum(checksum_a)
    );

    always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];

    // Instance B: single byte at the top of the address space
    logic        reset_b = 1'b0, start_b = 1'b0, dn_wait_b = 1'b0;
    logic [15:0] rom_addr_b, dn_addr_b, execute_addr_b;
    logic [7:0]  rom_data_b, dn_data_b, checksum_b;
    logic        dn_go_b, dn_wr_b, execute_enable_b, cpu_hold_b, busy_b, done_b;

    boot_rom_loader #(.BOOT_LEN(1), .LOAD_BASE(16'hFFFF), .EXEC_ADDR(16'h1234)) dut_b (
        .clk_sys(clk), .reset(reset_b), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .dn_go(dn_go_b), .dn_wr(dn_wr_b), .dn_addr(dn_addr_b), .dn_data(dn_data_b),
        .dn_wait(dn_wait_b), .execute_enable(execute_enable_b), .execute_addr(execute_addr_b),
        .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .checksum(checksum_b)
    );

    always @(posedge clk) rom_data_b <= 8'hA5 ^ rom_addr_b[7:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observer for instance A: records accepted bytes and execute pulses.
    typedef struct {
        int          edge_n;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t        acc_q[$];
    int          ee_q[$];
    int          stall_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] held_addr;
    logic [7:0]  held_data;

    always @(negedge clk) begin
        if (prev_stall)
            check("stall_hold", {dn_wr_a, dn_addr_a, dn_data_a}, {1'b1, held_addr, held_data});
        prev_stall = 1'b0;
        if (!reset_a && dn_wr_a) begin
            if (dn_wait_a) begin
                prev_stall = 1'b1;
                held_addr  = dn_addr_a;
                held_data  = dn_data_a;
                stall_cnt++;
            end else begin
                acc_q.push_back('{cyc + 1, dn_addr_a, dn_data_a});
            end
        end
        if (execute_enable_a) ee_q.push_back(cyc);
    end

    // One complete load on instance A, checked against the ROM image.
    task automatic do_load(input int n, input int wait_byte, input int wait_len,
                           input bit rand_wait, input int pulse_byte, input string tag);
        int         e0, wl, last_edge, done_edge;
        bit         fin, wstarted;
        logic [7:0] sum;
        acc_q.delete();
        ee_q.delete();
        stall_cnt = 0;
        wl = 0; fin = 0; wstarted = 0; done_edge = 0;
        start_a = 1'b1;
        tick();
        e0 = cyc;
        start_a = 1'b0;
        for (int t = 0; t < 4000 && !fin; t++) begin
            start_a = (pulse_byte >= 0 && dn_wr_a && dn_addr_a == 16'(pulse_byte));
            if (rand_wait) begin
                dn_wait_a = ($urandom_range(0, 2) == 0);
            end else begin
                if (wait_byte >= 0 && !wstarted && dn_wr_a && dn_addr_a == 16'(wait_byte)) begin
                    wstarted = 1'b1;
                    wl = wait_len;
                end
                dn_wait_a = (wl > 0);
                if (wl > 0) wl--;
            end
            tick();
            if (done_a) begin
                fin = 1'b1;
                done_edge = cyc;
            end
        end
        start_a = 1'b0;
        dn_wait_a = 1'b0;
        check({tag, "_finished"}, 64'(fin), 64'd1);
        check({tag, "_count"}, 64'(acc_q.size()), 64'(n));
        sum = 8'd0;
        for (int k = 0; k < n; k++) sum += rom_a[k];
        for (int k = 0; k < acc_q.size() && k < n; k++) begin
            check($sformatf("%s_addr%0d", tag, k), 64'(acc_q[k].addr), 64'(k));
            check($sformatf("%s_data%0d", tag, k), 64'(acc_q[k].data), 64'(rom_a[k]));
            if (stall_cnt == 0)
                check($sformatf("%s_edge%0d", tag, k), 64'(acc_q[k].edge_n), 64'(e0 + 2 * k + 3));
        end
        last_edge = e0 + 2 * n + 1 + stall_cnt;
        if (wait_byte >= 0) check({tag, "_stalls"}, 64'(stall_cnt), 64'(wait_len));
        if (acc_q.size() > 0) check({tag, "_last_edge"}, 64'(acc_q[$].edge_n), 64'(last_edge));
        check({tag, "_ee_count"}, 64'(ee_q.size()), 64'd1);
        if (ee_q.size() == 1) check({tag, "_ee_edge"}, 64'(ee_q[0]), 64'(last_edge));
        check({tag, "_done_edge"}, 64'(done_edge), 64'(last_edge + 1));
        check({tag, "_checksum"}, 64'(checksum_a), 64'(sum));
        check({tag, "_idle_flags"}, {busy_a, dn_go_a, cpu_hold_a, execute_enable_a, done_a}, 5'b00001);
        $display("load %s: %0d bytes, %0d stall cycles, checksum %02h", tag, acc_q.size(), stall_cnt, checksum_a);
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        wt;
        logic [37:0] exp;
    } row_t;

    function automatic logic [37:0] pk(input logic go, input logic wr, input logic [15:0] addr,
                                       input logic [7:0] data, input logic ee, input logic hold,
                                       input logic bsy, input logic dne, input logic [7:0] chk);
        return {go, wr, addr, data, ee, hold, bsy, dne, chk};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows [14];
        logic [37:0] z, f1, w, e, d, f2;
        int   e0;
        bit   found;

        for (int i = 0; i < 65536; i++) rom_a[i] = 8'(i);

        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;
        check("reset_state_a",
              {rom_addr_a, dn_addr_a, dn_data_a, checksum_a, execute_addr_a,
               dn_go_a, dn_wr_a, execute_enable_a, cpu_hold_a, busy_a, done_a}, 64'd0);
        check("exec_addr_b", 64'(execute_addr_b), 64'h1234);

        // Table-driven control sequence on the one-byte instance
        z  = pk(0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 8'h00);
        f1 = pk(1, 0, 16'h0000, 8'h00, 0, 1, 1, 0, 8'h00);
        w  = pk(1, 1, 16'hFFFF, 8'hA5, 0, 1, 1, 0, 8'h00);
        e  = pk(0, 0, 16'hFFFF, 8'hA5, 1, 0, 0, 0, 8'hA5);
        d  = pk(0, 0, 16'hFFFF, 8'hA5, 0, 0, 0, 1, 8'hA5);
        f2 = pk(1, 0, 16'hFFFF, 8'hA5, 0, 1, 1, 0, 8'h00);
        rows[0]  = '{1'b1, 1'b1, 1'b0, z};
        rows[1]  = '{1'b0, 1'b0, 1'b0, z};
        rows[2]  = '{1'b0, 1'b1, 1'b0, f1};
        rows[3]  = '{1'b0, 1'b0, 1'b0, f1};
        rows[4]  = '{1'b0, 1'b0, 1'b1, w};
        rows[5]  = '{1'b0, 1'b0, 1'b1, w};
        rows[6]  = '{1'b0, 1'b0, 1'b0, e};
        rows[7]  = '{1'b0, 1'b1, 1'b0, d};
        rows[8]  = '{1'b0, 1'b0, 1'b0, d};
        rows[9]  = '{1'b0, 1'b1, 1'b0, f2};
        rows[10] = '{1'b1, 1'b0, 1'b0, z};
        rows[11] = '{1'b0, 1'b0, 1'b0, z};
        rows[12] = '{1'b0, 1'b1, 1'b1, f1};
        rows[13] = '{1'b1, 1'b1, 1'b0, z};
        for (int i = 0; i < 14; i++) begin
            reset_b   = rows[i].rst;
            start_b   = rows[i].st;
            dn_wait_b = rows[i].wt;
            tick();
            check($sformatf("row%0d", i),
                  {dn_go_b, dn_wr_b, dn_addr_b, dn_data_b, execute_enable_b,
                   cpu_hold_b, busy_b, done_b, checksum_b}, rows[i].exp);
            $display("row %0d: rst=%0b start=%0b wait=%0b -> wr=%0b addr=%04h data=%02h ee=%0b done=%0b",
                     i, rows[i].rst, rows[i].st, rows[i].wt, dn_wr_b, dn_addr_b, dn_data_b,
                     execute_enable_b, done_b);
        end
        reset_b = 1'b0;
        start_b = 1'b0;
        dn_wait_b = 1'b0;

        // Default image, no backpressure
        do_load(276, -1, 0, 1'b0, -1, "default");

        // Five-cycle stall on byte 3 with a random image
        for (int i = 0; i < 276; i++) rom_a[i] = 8'($urandom);
        do_load(276, 3, 5, 1'b0, -1, "stall3");

        // Start pulsed mid-load has no effect
        do_load(276, -1, 0, 1'b0, 50, "restart50");

        // Random backpressure with a fresh random image
        for (int i = 0; i < 276; i++) rom_a[i] = 8'($urandom);
        do_load(276, -1, 0, 1'b1, -1, "randwait");

        // Start held high: a second full load follows DONE
        acc_q.delete();
        ee_q.delete();
        start_a = 1'b1;
        tick();
        e0 = cyc;
        for (int t = 0; t < 2000 && ee_q.size() < 2; t++) tick();
        start_a = 1'b0;
        tick();
        check("hold_ee_count", 64'(ee_q.size()), 64'd2);
        if (ee_q.size() == 2) begin
            check("hold_ee0", 64'(ee_q[0]), 64'(e0 + 553));
            check("hold_ee1", 64'(ee_q[1]), 64'(e0 + 555 + 553));
        end
        check("hold_count", 64'(acc_q.size()), 64'd552);
        if (acc_q.size() == 552) begin
            check("hold_second_first", {acc_q[276].addr, acc_q[276].data}, {16'd0, rom_a[0]});
            check("hold_second_last", {acc_q[551].addr, acc_q[551].data}, {16'd275, rom_a[275]});
        end
        repeat (5) tick();
        check("hold_no_third", {busy_a, done_a}, 2'b01);
        $display("load hold: %0d bytes, %0d execute pulses", acc_q.size(), ee_q.size());

        // Reset while byte 100 is in WRITE
        acc_q.delete();
        ee_q.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 400 && !found; t++) begin
            if (dn_wr_a && dn_addr_a == 16'd100) found = 1'b1;
            else tick();
        end
        check("abort_reached_100", 64'(found), 64'd1);
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        check("abort_outputs",
              {rom_addr_a, dn_addr_a, dn_data_a, checksum_a,
               dn_go_a, dn_wr_a, execute_enable_a, cpu_hold_a, busy_a, done_a}, 64'd0);
        acc_q.delete();
        repeat (600) tick();
        check("abort_no_writes", 64'(acc_q.size()), 64'd0);
        check("abort_no_exec", 64'(ee_q.size()), 64'd0);
        check("abort_idle", {busy_a, dn_go_a, done_a}, 3'b000);
        $display("abort: %0d writes and %0d execute pulses after reset", acc_q.size(), ee_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
